// File: rtl/brc_arbiter_if.sv
// ============================================================================
// Module   : brc_arbiter_if
// Brief    : Request/response bundle between two requesters and brc_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface brc_arbiter_if #(
   parameter int XLEN = 32
);
   logic            i_req0_valid;
   logic            o_req0_ready;
   logic [XLEN-1:0] i_req0_rs1;
   logic [XLEN-1:0] i_req0_rs2;
   logic [2:0]      i_req0_op;
   logic            o_rsp0_valid;
   logic            i_rsp0_ready;
   logic            o_rsp0_taken;
   logic            o_rsp0_err;

   logic            i_req1_valid;
   logic            o_req1_ready;
   logic [XLEN-1:0] i_req1_rs1;
   logic [XLEN-1:0] i_req1_rs2;
   logic [2:0]      i_req1_op;
   logic            o_rsp1_valid;
   logic            i_rsp1_ready;
   logic            o_rsp1_taken;
   logic            o_rsp1_err;

   modport master (
      output i_req0_valid, i_req0_rs1, i_req0_rs2, i_req0_op, i_rsp0_ready,
      output i_req1_valid, i_req1_rs1, i_req1_rs2, i_req1_op, i_rsp1_ready,
      input  o_req0_ready, o_rsp0_valid, o_rsp0_taken, o_rsp0_err,
      input  o_req1_ready, o_rsp1_valid, o_rsp1_taken, o_rsp1_err
   );

   modport slave (
      input  i_req0_valid, i_req0_rs1, i_req0_rs2, i_req0_op, i_rsp0_ready,
      input  i_req1_valid, i_req1_rs1, i_req1_rs2, i_req1_op, i_rsp1_ready,
      output o_req0_ready, o_rsp0_valid, o_rsp0_taken, o_rsp0_err,
      output o_req1_ready, o_rsp1_valid, o_rsp1_taken, o_rsp1_err
   );
endinterface

`default_nettype wire

// File: rtl/brc_arbiter.sv
// ============================================================================
// Module   : brc_arbiter
// Brief    : Round-robin share of one branch comparator between two requesters.
//            Optional macro BRC_ARB_FASTPATH_EN: compare in IDLE, skip CMP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module brc_arbiter #(
   parameter int XLEN = 32
) (
   input  wire logic     i_clk,
   input  wire logic     i_reset,
   brc_arbiter_if.slave  bus,
   output logic          o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   ptr_q, ptr_d;
   logic   owner_q, owner_d;
   logic   taken_q, taken_d;
   logic   err_q, err_d;

   logic            w_gnt0, w_gnt1, w_fire, w_gnt_id, w_rsp_v;
   logic [XLEN-1:0] w_cmp_a, w_cmp_b;
   logic [2:0]      w_cmp_op;
   logic            w_br_un, w_br_eq, w_br_lt;
   logic            w_cond_taken, w_cond_err;

`ifndef BRC_ARB_FASTPATH_EN
   logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2:0]      op_q, op_d;
`endif

   // Ready is withheld during reset so every output reads 0 while it is held.
   assign w_gnt0   = (state_q == S_IDLE) && !i_reset && bus.i_req0_valid &&
                     (!bus.i_req1_valid || !ptr_q);
   assign w_gnt1   = (state_q == S_IDLE) && !i_reset && bus.i_req1_valid &&
                     (!bus.i_req0_valid || ptr_q);
   assign w_fire   = w_gnt0 || w_gnt1;
   assign w_gnt_id = w_gnt1;

`ifdef BRC_ARB_FASTPATH_EN
   assign w_cmp_a  = w_gnt_id ? bus.i_req1_rs1 : bus.i_req0_rs1;
   assign w_cmp_b  = w_gnt_id ? bus.i_req1_rs2 : bus.i_req0_rs2;
   assign w_cmp_op = w_gnt_id ? bus.i_req1_op  : bus.i_req0_op;
`else
   assign w_cmp_a  = rs1_q;
   assign w_cmp_b  = rs2_q;
   assign w_cmp_op = op_q;
`endif

   assign w_br_un = w_cmp_op[1];
   assign w_br_eq = (w_cmp_a == w_cmp_b);
   assign w_br_lt = w_br_un ? (w_cmp_a < w_cmp_b)
                            : ($signed(w_cmp_a) < $signed(w_cmp_b));

   always_comb begin
      w_cond_taken = 1'b0;
      w_cond_err   = 1'b0;
      case (w_cmp_op)
         3'b000:          w_cond_taken = w_br_eq;
         3'b001:          w_cond_taken = !w_br_eq;
         3'b100, 3'b110:  w_cond_taken = w_br_lt;
         3'b101, 3'b111:  w_cond_taken = !w_br_lt;
         default:         w_cond_err   = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      taken_d = taken_q;
      err_d   = err_q;
`ifndef BRC_ARB_FASTPATH_EN
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      op_d    = op_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (w_fire) begin
               ptr_d   = !w_gnt_id;
               owner_d = w_gnt_id;
`ifdef BRC_ARB_FASTPATH_EN
               taken_d = w_cond_taken;
               err_d   = w_cond_err;
               state_d = S_RESP;
`else
               rs1_d   = w_gnt_id ? bus.i_req1_rs1 : bus.i_req0_rs1;
               rs2_d   = w_gnt_id ? bus.i_req1_rs2 : bus.i_req0_rs2;
               op_d    = w_gnt_id ? bus.i_req1_op  : bus.i_req0_op;
               state_d = S_CMP;
`endif
            end
         end
         S_CMP: begin
            taken_d = w_cond_taken;
            err_d   = w_cond_err;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (owner_q ? bus.i_rsp1_ready : bus.i_rsp0_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         taken_q <= 1'b0;
         err_q   <= 1'b0;
`ifndef BRC_ARB_FASTPATH_EN
         rs1_q   <= '0;
         rs2_q   <= '0;
         op_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         taken_q <= taken_d;
         err_q   <= err_d;
`ifndef BRC_ARB_FASTPATH_EN
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         op_q    <= op_d;
`endif
      end
   end

   assign w_rsp_v          = (state_q == S_RESP);
   assign bus.o_req0_ready = w_gnt0;
   assign bus.o_req1_ready = w_gnt1;
   assign bus.o_rsp0_valid = w_rsp_v && !owner_q;
   assign bus.o_rsp1_valid = w_rsp_v &&  owner_q;
   assign bus.o_rsp0_taken = bus.o_rsp0_valid && taken_q;
   assign bus.o_rsp1_taken = bus.o_rsp1_valid && taken_q;
   assign bus.o_rsp0_err   = bus.o_rsp0_valid && err_q;
   assign bus.o_rsp1_err   = bus.o_rsp1_valid && err_q;
   assign o_busy           = (state_q != S_IDLE);

endmodule

`default_nettype wire
